// File: rtl/store_queue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// store_queue_ctrl_pkg
// Shared constants for the posted-store queue:
//   - store / load opcode encodings
//   - big-endian byte-lane masks (bit 3 = byte at address offset 00)
//   - width of one queued entry: {word address, lane-aligned data, lane enables}
//   - drain state machine encoding
// ---------------------------------------------------------------------------
package store_queue_ctrl_pkg;

    localparam logic [5:0] OP_SB         = 6'b101000;
    localparam logic [5:0] OP_SH         = 6'b101001;
    localparam logic [5:0] OP_SW         = 6'b101011;
    localparam logic [2:0] OP_LOAD_CLASS = 3'b100;

    localparam logic [3:0] LANE_NONE    = 4'b0000;
    localparam logic [3:0] LANE_WORD    = 4'b1111;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_BYTE0   = 4'b1000;
    localparam logic [3:0] LANE_BYTE1   = 4'b0100;
    localparam logic [3:0] LANE_BYTE2   = 4'b0010;
    localparam logic [3:0] LANE_BYTE3   = 4'b0001;

    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    // One entry holds the word address only; the byte offset is folded
    // into the lane enables.
    function automatic int entryWidth(input int addrW);
        return addrW - 2 + DATA_W + WE_W;
    endfunction

    typedef enum logic {
        IDLE,
        ISSUE
    } drain_state_t;

endpackage

// File: rtl/store_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_queue_ctrl_if
// Data-memory write port between the store queue (master) and memory (slave).
//   memReqValid  master->slave  head entry presented
//   memReqReady  slave->master  memory accepts the head this cycle
//   memAddr      master->slave  word-aligned byte address
//   memWData     master->slave  lane-aligned write data
//   memWE        master->slave  byte-lane enables, bit3 = byte at offset 00
// ---------------------------------------------------------------------------
interface store_queue_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic              memReqValid;
    logic              memReqReady;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWData;
    logic [3:0]        memWE;

    modport master (
        output memReqValid,
        output memAddr,
        output memWData,
        output memWE,
        input  memReqReady
    );

    modport slave (
        input  memReqValid,
        input  memAddr,
        input  memWData,
        input  memWE,
        output memReqReady
    );

endinterface

// File: rtl/store_queue_ctrl_lane_gen.sv
// ---------------------------------------------------------------------------
// store_lane_gen
// Combinational store decode: turns an execute-stage opcode, the low address
// bits and the source register into big-endian byte-lane enables and
// lane-replicated write data.
//   opcode   in   6   execute-stage opcode
//   addrLow  in   2   byte offset of the effective address
//   dataIn   in   32  store source register value
//   we       out  4   byte-lane enables (0000 for non-stores)
//   wdata    out  32  lane-aligned write data
//   isStore  out  1   opcode is SB, SH or SW
// ---------------------------------------------------------------------------
module store_lane_gen
    import store_queue_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addrLow,
    input  logic [31:0] dataIn,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic        isStore
);

    // Misaligned halfwords/words are not trapped: SH looks only at addr[1],
    // SW ignores the offset entirely.
    always_comb begin
        we      = LANE_NONE;
        wdata   = dataIn;
        isStore = 1'b0;
        case (opcode)
            OP_SB: begin
                isStore = 1'b1;
                wdata   = {4{dataIn[7:0]}};
                case (addrLow)
                    2'b00:   we = LANE_BYTE0;
                    2'b01:   we = LANE_BYTE1;
                    2'b10:   we = LANE_BYTE2;
                    default: we = LANE_BYTE3;
                endcase
            end
            OP_SH: begin
                isStore = 1'b1;
                wdata   = {2{dataIn[15:0]}};
                we      = addrLow[1] ? LANE_HALF_LO : LANE_HALF_HI;
            end
            OP_SW: begin
                isStore = 1'b1;
                we      = LANE_WORD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_queue_ctrl.sv
// ---------------------------------------------------------------------------
// store_queue_ctrl
// Posted-store queue between execute and the data-memory write port. Stores
// are decoded, lane-aligned, buffered in order (DEPTH entries) and drained
// over a valid/ready handshake.
//   clk, rst      clock and asynchronous active-high reset
//   opcodeE       execute-stage opcode
//   ALUoutE       effective byte address
//   storeDataE    store source register value
//   stallE        store presented while the queue is full (not accepted)
//   loadHazardE   load hits the word address of a queued store
//   queueEmpty    no pending stores
//   mem           memory write port (master side)
// Build option: STORE_QUEUE_HAZARD_EN builds the load/store address
// comparators; without it loadHazardE is tied low.
// ---------------------------------------------------------------------------
module store_queue_ctrl
    import store_queue_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcodeE,
    input  logic [ADDR_W-1:0]  ALUoutE,
    input  logic [31:0]        storeDataE,
    output logic               stallE,
    output logic               loadHazardE,
    output logic               queueEmpty,
    store_queue_ctrl_if.master mem
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WADDR_W = ADDR_W - 2;
    localparam int ENTRY_W = entryWidth(ADDR_W);

    logic [ENTRY_W-1:0] entries [DEPTH];
    logic [DEPTH-1:0]   entValid;
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   count;
    drain_state_t       state;

    logic [3:0]         laneWe;
    logic [31:0]        laneData;
    logic               isStore;
    logic               queueFull;
    logic               push;
    logic               pop;
    logic               reqValid;
    logic [ENTRY_W-1:0] headEntry;

    store_lane_gen u_laneGen (
        .opcode  (opcodeE),
        .addrLow (ALUoutE[1:0]),
        .dataIn  (storeDataE),
        .we      (laneWe),
        .wdata   (laneData),
        .isStore (isStore)
    );

    // No bypass: a pop in the same cycle does not free a slot for a store
    // that arrives while the registered count says full.
    assign queueFull  = (count == CNT_W'(DEPTH));
    assign push       = isStore & ~queueFull;
    assign stallE     = isStore & queueFull;
    assign queueEmpty = (count == '0);
    assign reqValid   = (state == ISSUE);
    assign pop        = reqValid & mem.memReqReady;

    // Entry payload needs no reset; the valid bits and count decide what
    // is live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tailPtr] <= {ALUoutE[ADDR_W-1:2], laneData, laneWe};
        end
    end

    // Pointers, occupancy and the drain state machine. ISSUE tracks
    // count != 0 exactly, so memReqValid comes straight from the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            entValid <= '0;
            state    <= IDLE;
        end else begin
            if (pop) begin
                entValid[headPtr] <= 1'b0;
                headPtr           <= headPtr + PTR_W'(1);
            end
            if (push) begin
                entValid[tailPtr] <= 1'b1;
                tailPtr           <= tailPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (pop && (count == CNT_W'(1)) && !push) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is gated by valid so the port reads all-zero whenever
    // nothing is pending, including throughout reset.
    assign headEntry    = entries[headPtr];
    assign mem.memReqValid = reqValid;
    assign mem.memAddr  = reqValid ? {headEntry[ENTRY_W-1 -: WADDR_W], 2'b00} : '0;
    assign mem.memWData = reqValid ? headEntry[DATA_W+WE_W-1 : WE_W] : '0;
    assign mem.memWE    = reqValid ? headEntry[WE_W-1:0] : '0;

`ifdef STORE_QUEUE_HAZARD_EN
    logic isLoad;
    logic addrHit;

    assign isLoad = (opcodeE[5:3] == OP_LOAD_CLASS);

    // Word-granular match against every live entry.
    always_comb begin
        addrHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entValid[i] && (entries[i][ENTRY_W-1 -: WADDR_W] == ALUoutE[ADDR_W-1:2])) begin
                addrHit = 1'b1;
            end
        end
    end

    assign loadHazardE = isLoad & addrHit;
`else
    logic unusedHazardSink;

    assign unusedHazardSink = ^entValid;
    assign loadHazardE      = 1'b0;
`endif

endmodule
